scoreboard_hazard_unit: RTL and testbench

SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

---
 rtl/scoreboard_hazard_unit_pkg.sv | 16 +
 rtl/scoreboard_hazard_unit_fwd_select.sv | 28 ++
 rtl/scoreboard_hazard_unit.sv | 168 ++++++++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared definitions for the scoreboard hazard unit.
//   state_e  : control FSM states (RUN, MEMWAIT, BFLUSH)
//   FWD_*    : forward-select encodings driven on forward_* outputs
package scoreboard_hazard_unit_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StBFlush  = 2'b10
    } state_e;

    localparam logic [1:0] FWD_RF = 2'b00;  // register file value
    localparam logic [1:0] FWD_W  = 2'b01;  // writeback-stage result
    localparam logic [1:0] FWD_M  = 2'b10;  // memory-stage result

endpackage

// File: rtl/scoreboard_hazard_unit_fwd_select.sv
// Forwarding comparator for one execute-stage source operand.
//   ra_i                     : source register address
//   regwrite_m_i / wa_m_i    : memory-stage write enable and destination
//   regwrite_w_i / wa_w_i    : writeback-stage write enable and destination
//   fwd_o                    : FWD_M, FWD_W or FWD_RF (memory stage wins)
module fwd_select
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 3
) (
    input  logic [REG_AW-1:0] ra_i,
    input  logic              regwrite_m_i,
    input  logic [REG_AW-1:0] wa_m_i,
    input  logic              regwrite_w_i,
    input  logic [REG_AW-1:0] wa_w_i,
    output logic [1:0]        fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (regwrite_m_i && (wa_m_i == ra_i)) begin
            fwd_o = FWD_M;
        end else if (regwrite_w_i && (wa_w_i == ra_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, taken-branch flush
// and data-access busy stall with timeout abort.
//   clk, rst_n                          : clock, async active-low reset
//   ra1_d, ra2_d                        : decode-stage source registers
//   ra1_e, ra2_e, wa3_e, memtoreg_e     : execute-stage regs / load flag
//   branch_taken_e                      : taken branch resolved in execute
//   regwrite_m/vm, wa3_m, busy_da       : memory-stage writes, data-access busy
//   regwrite_w/vw, wa3_w                : writeback-stage writes
//   stall_*/flush_*                     : pipeline control
//   forward_ae/be/ave/bve               : forward selects (scalar and vector)
//   timeout_err                         : sticky busy timeout abort
//   stall_cnt                           : saturating count of stalled fetch cycles
module scoreboard_hazard_unit
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_AW      = 3,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra1_d,
    input  logic [REG_AW-1:0] ra2_d,
    input  logic [REG_AW-1:0] ra1_e,
    input  logic [REG_AW-1:0] ra2_e,
    input  logic [REG_AW-1:0] wa3_e,
    input  logic              memtoreg_e,
    input  logic              branch_taken_e,
    input  logic              regwrite_m,
    input  logic              regwrite_vm,
    input  logic [REG_AW-1:0] wa3_m,
    input  logic              busy_da,
    input  logic              regwrite_w,
    input  logic              regwrite_vw,
    input  logic [REG_AW-1:0] wa3_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              stall_e,
    output logic              flush_e,
    output logic              stall_m,
    output logic              stall_w,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic [1:0]        forward_ave,
    output logic [1:0]        forward_bve,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned WaitW  = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned FlushW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    // ---------------- forwarding ----------------
    fwd_select #(.REG_AW(REG_AW)) u_fwd_ae (
        .ra_i(ra1_e), .regwrite_m_i(regwrite_m), .wa_m_i(wa3_m),
        .regwrite_w_i(regwrite_w), .wa_w_i(wa3_w), .fwd_o(forward_ae)
    );
    fwd_select #(.REG_AW(REG_AW)) u_fwd_be (
        .ra_i(ra2_e), .regwrite_m_i(regwrite_m), .wa_m_i(wa3_m),
        .regwrite_w_i(regwrite_w), .wa_w_i(wa3_w), .fwd_o(forward_be)
    );
    fwd_select #(.REG_AW(REG_AW)) u_fwd_ave (
        .ra_i(ra1_e), .regwrite_m_i(regwrite_vm), .wa_m_i(wa3_m),
        .regwrite_w_i(regwrite_vw), .wa_w_i(wa3_w), .fwd_o(forward_ave)
    );
    fwd_select #(.REG_AW(REG_AW)) u_fwd_bve (
        .ra_i(ra2_e), .regwrite_m_i(regwrite_vm), .wa_m_i(wa3_m),
        .regwrite_w_i(regwrite_vw), .wa_w_i(wa3_w), .fwd_o(forward_bve)
    );

    // ---------------- control FSM ----------------
    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [FlushW-1:0]  flush_cnt_q, flush_cnt_d;
    logic               timeout_q, timeout_d;
    logic               abort_q, abort_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic busy_eff, load_use;
    logic mem_stall, lu_stall, flush_d_c, flush_e_c;

    // The cycle after a timeout ignores busy_da so the pipeline is released.
    assign busy_eff = busy_da & ~abort_q;
    assign load_use = memtoreg_e & ((wa3_e == ra1_d) | (wa3_e == ra2_d));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        timeout_d   = timeout_q;
        abort_d     = 1'b0;
        mem_stall   = 1'b0;
        lu_stall    = 1'b0;
        flush_d_c   = 1'b0;
        flush_e_c   = 1'b0;

        if (busy_eff) begin
            mem_stall = 1'b1;
            // wait_cnt_q holds busy cycles already seen; this cycle is one more.
            if (32'(wait_cnt_q) + 32'd1 >= MEM_TIMEOUT) begin
                timeout_d   = 1'b1;
                abort_d     = 1'b1;
                wait_cnt_d  = '0;
                flush_cnt_d = '0;
                state_d     = StRun;
            end else begin
                wait_cnt_d = wait_cnt_q + WaitW'(1);
                state_d    = StMemWait;
            end
        end else begin
            wait_cnt_d = '0;
            // A flush interrupted by busy_da resumes straight out of MEMWAIT.
            if ((state_q != StRun) && (flush_cnt_q != '0)) begin
                flush_d_c   = 1'b1;
                flush_cnt_d = flush_cnt_q - FlushW'(1);
                state_d     = (flush_cnt_q > FlushW'(1)) ? StBFlush : StRun;
            end else if (branch_taken_e) begin
                flush_d_c   = 1'b1;
                flush_e_c   = 1'b1;
                flush_cnt_d = FlushW'(FLUSH_DEPTH - 1);
                state_d     = (FLUSH_DEPTH > 1) ? StBFlush : StRun;
            end else begin
                lu_stall  = load_use;
                flush_e_c = load_use;
                state_d   = StRun;
            end
        end
    end

    // Outputs are forced low while reset is asserted, independent of the clock.
    assign stall_f     = rst_n & (mem_stall | lu_stall);
    assign stall_d     = rst_n & (mem_stall | lu_stall);
    assign stall_e     = rst_n & mem_stall;
    assign stall_m     = rst_n & mem_stall;
    assign stall_w     = rst_n & mem_stall;
    assign flush_d     = rst_n & flush_d_c;
    assign flush_e     = rst_n & flush_e_c;
    assign timeout_err = timeout_q;
    assign stall_cnt   = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
            abort_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
            abort_q     <= abort_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench for scoreboard_hazard_unit (FLUSH_DEPTH=3, MEM_TIMEOUT=5).
module tb_scoreboard_hazard_unit;

    localparam int FD = 3;
    localparam int TO = 5;
    localparam int CMAX = 65535;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
    logic       memtoreg_e, branch_taken_e, regwrite_m, regwrite_vm, busy_da;
    logic       regwrite_w, regwrite_vw;
    logic       stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, stall_w;
    logic [1:0] forward_ae, forward_be, forward_ave, forward_bve;
    logic       timeout_err;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_waited, m_flush_left, m_scnt;
    bit m_terr, m_abort;

    always #5 clk = ~clk;

    scoreboard_hazard_unit #(
        .REG_AW(3), .FLUSH_DEPTH(FD), .MEM_TIMEOUT(TO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ra1_d(ra1_d), .ra2_d(ra2_d), .ra1_e(ra1_e), .ra2_e(ra2_e), .wa3_e(wa3_e),
        .memtoreg_e(memtoreg_e), .branch_taken_e(branch_taken_e),
        .regwrite_m(regwrite_m), .regwrite_vm(regwrite_vm), .wa3_m(wa3_m),
        .busy_da(busy_da), .regwrite_w(regwrite_w), .regwrite_vw(regwrite_vw),
        .wa3_w(wa3_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .stall_e(stall_e),
        .flush_e(flush_e), .stall_m(stall_m), .stall_w(stall_w),
        .forward_ae(forward_ae), .forward_be(forward_be),
        .forward_ave(forward_ave), .forward_bve(forward_bve),
        .timeout_err(timeout_err), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [2:0] ra, input logic wm,
                                           input logic [2:0] am, input logic ww,
                                           input logic [2:0] aw);
        if (wm && am == ra) return 2'd2;
        if (ww && aw == ra) return 2'd1;
        return 2'd0;
    endfunction

    task automatic check_fwd();
        chk("forward_ae",  32'(forward_ae),  32'(fwd_ref(ra1_e, regwrite_m, wa3_m, regwrite_w, wa3_w)));
        chk("forward_be",  32'(forward_be),  32'(fwd_ref(ra2_e, regwrite_m, wa3_m, regwrite_w, wa3_w)));
        chk("forward_ave", 32'(forward_ave), 32'(fwd_ref(ra1_e, regwrite_vm, wa3_m, regwrite_vw, wa3_w)));
        chk("forward_bve", 32'(forward_bve), 32'(fwd_ref(ra2_e, regwrite_vm, wa3_m, regwrite_vw, wa3_w)));
    endtask

    task automatic model_reset();
        m_waited = 0; m_flush_left = 0; m_scnt = 0; m_terr = 0; m_abort = 0;
    endtask

    // One clock cycle: predict from the rules, compare mid-cycle, advance model.
    task automatic step();
        bit mem, lu, fd, fe, n_abort;
        int n_wait, n_flush;
        @(negedge clk);
        mem = 0; lu = 0; fd = 0; fe = 0; n_abort = 0;
        n_wait = 0; n_flush = m_flush_left;
        if (busy_da && !m_abort) begin
            mem = 1;
            if (m_waited + 1 >= TO) begin
                n_abort = 1; n_flush = 0;
            end else begin
                n_wait = m_waited + 1;
            end
        end else if (m_flush_left > 0) begin
            fd = 1; n_flush = m_flush_left - 1;
        end else if (branch_taken_e) begin
            fd = 1; fe = 1; n_flush = FD - 1;
        end else if (memtoreg_e && (wa3_e == ra1_d || wa3_e == ra2_d)) begin
            lu = 1; fe = 1;
        end
        chk("stall_f", 32'(stall_f), 32'(mem | lu));
        chk("stall_d", 32'(stall_d), 32'(mem | lu));
        chk("stall_e", 32'(stall_e), 32'(mem));
        chk("stall_m", 32'(stall_m), 32'(mem));
        chk("stall_w", 32'(stall_w), 32'(mem));
        chk("flush_d", 32'(flush_d), 32'(fd));
        chk("flush_e", 32'(flush_e), 32'(fe));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
        check_fwd();
        @(posedge clk);
        if (n_abort) m_terr = 1;
        m_abort = n_abort; m_waited = n_wait; m_flush_left = n_flush;
        if ((mem || lu) && m_scnt < CMAX) m_scnt++;
        #1;
    endtask

    task automatic idle_inputs();
        ra1_d = 0; ra2_d = 0; ra1_e = 0; ra2_e = 0; wa3_e = 0; wa3_m = 0; wa3_w = 0;
        memtoreg_e = 0; branch_taken_e = 0; regwrite_m = 0; regwrite_vm = 0;
        busy_da = 0; regwrite_w = 0; regwrite_vw = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("reset_stall_f", 32'(stall_f), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_timeout", 32'(timeout_err), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        step();

        // Forwarding: M beats W, then W alone, vector path alike
        ra1_e = 3; regwrite_m = 1; wa3_m = 3; regwrite_w = 1; wa3_w = 3;
        #1 chk("fwd_ae_m", 32'(forward_ae), 32'd2);
        regwrite_m = 0;
        #1 chk("fwd_ae_w", 32'(forward_ae), 32'd1);
        regwrite_w = 0; regwrite_vm = 1; regwrite_vw = 1; ra2_e = 3;
        #1 chk("fwd_bve_m", 32'(forward_bve), 32'd2);
        regwrite_vm = 0;
        #1 chk("fwd_bve_w", 32'(forward_bve), 32'd1);
        step();
        idle_inputs();

        // Load-use: one cycle of stall_f/stall_d/flush_e
        memtoreg_e = 1; wa3_e = 2; ra2_d = 2; ra1_d = 5;
        step();
        memtoreg_e = 0;
        step();
        chk("loaduse_cnt", 32'(stall_cnt), 32'd1);

        // Branch pulse with FLUSH_DEPTH=3
        branch_taken_e = 1; step();
        branch_taken_e = 0; repeat (3) step();

        // busy_da for 4 cycles
        busy_da = 1; repeat (4) step();
        busy_da = 0; step();

        // busy_da and branch together: stalls first, flush when busy falls
        busy_da = 1; branch_taken_e = 1; repeat (2) step();
        busy_da = 0; step();
        branch_taken_e = 0; repeat (3) step();

        // busy_da interrupting a branch flush, flush resumes afterwards
        branch_taken_e = 1; step();
        branch_taken_e = 0; busy_da = 1; repeat (2) step();
        busy_da = 0; repeat (3) step();

        // Reset asserted mid-MEMWAIT
        busy_da = 1; repeat (2) step();
        rst_n = 1'b0; ra1_e = 4; wa3_m = 4; regwrite_m = 1;
        #1;
        chk("rst_mid_stall_f", 32'(stall_f), 32'd0);
        chk("rst_mid_stall_w", 32'(stall_w), 32'd0);
        chk("rst_mid_flush_d", 32'(flush_d), 32'd0);
        chk("rst_mid_fwd", 32'(forward_ae), 32'd2);
        model_reset();
        busy_da = 0;
        #3 rst_n = 1'b1;
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        step();

        // Timeout: hold busy_da through MEM_TIMEOUT cycles
        busy_da = 1; repeat (TO + 1) step();
        chk("timeout_set", 32'(timeout_err), 32'd1);
        busy_da = 0; repeat (2) step();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            ra1_d = 3'($urandom_range(0, 7)); ra2_d = 3'($urandom_range(0, 7));
            ra1_e = 3'($urandom_range(0, 7)); ra2_e = 3'($urandom_range(0, 7));
            wa3_e = 3'($urandom_range(0, 7)); wa3_m = 3'($urandom_range(0, 7));
            wa3_w = 3'($urandom_range(0, 7));
            memtoreg_e = ($urandom_range(0, 2) == 0);
            branch_taken_e = ($urandom_range(0, 5) == 0);
            busy_da = ($urandom_range(0, 3) == 0);
            regwrite_m = 1'($urandom); regwrite_vm = 1'($urandom);
            regwrite_w = 1'($urandom); regwrite_vw = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
